mem_access_stage: RTL and testbench

//  MEM stage: consumes EX/MEM register outputs and drives the data-memory port.

---
 rtl/mem_access_stage_pkg.sv | 20 ++
 rtl/mem_access_stage_byte_lane_align.sv | 24 ++
 rtl/mem_access_stage.sv | 153 +++++++++++++++
 tb/tb_mem_access_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: access FSM states, address-select codes and
// the word-alignment helper.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_IND,
        MEM_DONE
    } lc3b_mem_state;

    localparam logic [1:0] ADDRSEL_ALU   = 2'd0;
    localparam logic [1:0] ADDRSEL_ADDER = 2'd1;
    localparam logic [1:0] ADDRSEL_TRAP  = 2'd2;

    // Word accesses ignore the low address bit; byte accesses keep it as the lane.
    function automatic logic [15:0] word_align(input logic [15:0] addr, input logic is_byte);
        return is_byte ? addr : {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_access_stage_byte_lane_align.sv
// Combinational byte-lane handling: lane select / zero-extend on reads,
// byte replication and lane enables on writes.
module byte_lane_align (
    input  logic        i_is_byte,
    input  logic        i_lane,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_rdata,
    output logic [1:0]  o_byte_enable,
    output logic [15:0] o_wdata,
    output logic [15:0] o_rdata
);

    always_comb begin
        o_byte_enable = 2'b11;
        o_wdata       = i_wdata;
        o_rdata       = i_rdata;
        if (i_is_byte) begin
            o_byte_enable = i_lane ? 2'b10 : 2'b01;
            o_wdata       = {i_wdata[7:0], i_wdata[7:0]};
            o_rdata       = i_lane ? {8'h00, i_rdata[15:8]} : {8'h00, i_rdata[7:0]};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory port for single and indirect
// (LDI/STI) accesses and stalls the pipeline until the access completes.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter bit INDIRECT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        is_ldi,
    input  logic        is_sti,
    input  logic        is_ldb_stb,
    input  logic [1:0]  addr_sel,
    input  logic [15:0] alu_out,
    input  logic [15:0] addr_adder_out,
    input  logic [15:0] trapvector,
    input  logic [15:0] dest_data,
    input  logic        ext_stall,
    input  logic        d_resp,
    input  logic [15:0] d_rdata,
    output logic        d_read,
    output logic        d_write,
    output logic [15:0] d_address,
    output logic [15:0] d_wdata,
    output logic [1:0]  d_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        mem_stall
);

    lc3b_mem_state r_state;
    lc3b_mem_state w_next_state;
    logic [15:0]   r_data;
    logic [15:0]   r_ind;

    logic          w_req;
    logic          w_indirect;
    logic [15:0]   w_sel_addr;
    logic [15:0]   w_raw_addr;
    logic          w_byte;
    logic          w_is_write;
    logic          w_access_en;
    logic          w_ind_load;
    logic          w_data_load;
    logic [15:0]   w_rdata_aligned;

    assign w_req      = mem_read | mem_write;
    assign w_indirect = INDIRECT_EN & (is_ldi | is_sti);

    always_comb begin
        unique case (addr_sel)
            ADDRSEL_ALU:   w_sel_addr = alu_out;
            ADDRSEL_ADDER: w_sel_addr = addr_adder_out;
            ADDRSEL_TRAP:  w_sel_addr = trapvector;
            default:       w_sel_addr = alu_out;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ind_load   = 1'b0;
        w_data_load  = 1'b0;
        unique case (r_state)
            MEM_IDLE: begin
                if (w_req && d_resp) begin
                    if (w_indirect) begin
                        w_ind_load   = 1'b1;
                        w_next_state = MEM_IND;
                    end else begin
                        w_data_load  = 1'b1;
                        w_next_state = MEM_DONE;
                    end
                end
            end
            MEM_IND: begin
                if (w_req && d_resp) begin
                    w_data_load  = 1'b1;
                    w_next_state = MEM_DONE;
                end
            end
            MEM_DONE: begin
                if (!ext_stall) begin
                    w_next_state = MEM_IDLE;
                end
            end
            default: w_next_state = MEM_IDLE;
        endcase
    end

    always_comb begin
        w_raw_addr  = w_sel_addr;
        w_byte      = 1'b0;
        w_is_write  = 1'b0;
        w_access_en = 1'b0;
        unique case (r_state)
            MEM_IDLE: begin
                // Pointer fetch of LDI/STI is always a word read.
                w_raw_addr  = w_sel_addr;
                w_byte      = is_ldb_stb & ~w_indirect;
                w_is_write  = mem_write & ~mem_read & ~w_indirect;
                w_access_en = w_req;
            end
            MEM_IND: begin
                w_raw_addr  = r_ind;
                w_byte      = is_ldb_stb;
                w_is_write  = is_sti & ~mem_read;
                w_access_en = w_req;
            end
            default: begin
                w_access_en = 1'b0;
            end
        endcase
        d_address = word_align(w_raw_addr, w_byte);
        d_read    = ~reset & w_access_en & ~w_is_write;
        d_write   = ~reset & w_access_en & w_is_write;
        mem_stall = ~reset & (ext_stall | (w_req & (r_state != MEM_DONE)));
        mem_rdata = (~reset && r_state == MEM_DONE) ? r_data : 16'h0000;
    end

    byte_lane_align u_align (
        .i_is_byte     (w_byte),
        .i_lane        (d_address[0]),
        .i_wdata       (dest_data),
        .i_rdata       (d_rdata),
        .o_byte_enable (d_byte_enable),
        .o_wdata       (d_wdata),
        .o_rdata       (w_rdata_aligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= 16'h0000;
            r_ind  <= 16'h0000;
        end else begin
            if (w_ind_load) begin
                r_ind <= d_rdata;
            end
            if (w_data_load) begin
                r_data <= w_rdata_aligned;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single accesses plus
// hand-written LDI/STI, DONE-hold, reset and stray-response sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, is_ldi, is_sti, is_ldb_stb;
    logic [1:0]  addr_sel;
    logic [15:0] alu_out, addr_adder_out, trapvector, dest_data;
    logic        ext_stall, d_resp;
    logic [15:0] d_rdata;
    logic        d_read, d_write;
    logic [15:0] d_address, d_wdata, mem_rdata;
    logic [1:0]  d_byte_enable;
    logic        mem_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .INDIRECT_EN (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .is_ldi         (is_ldi),
        .is_sti         (is_sti),
        .is_ldb_stb     (is_ldb_stb),
        .addr_sel       (addr_sel),
        .alu_out        (alu_out),
        .addr_adder_out (addr_adder_out),
        .trapvector     (trapvector),
        .dest_data      (dest_data),
        .ext_stall      (ext_stall),
        .d_resp         (d_resp),
        .d_rdata        (d_rdata),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_address      (d_address),
        .d_wdata        (d_wdata),
        .d_byte_enable  (d_byte_enable),
        .mem_rdata      (mem_rdata),
        .mem_stall      (mem_stall)
    );

    typedef struct {
        logic        mr;
        logic        mw;
        logic        byt;
        logic [1:0]  sel;
        logic [15:0] alu;
        logic [15:0] adder;
        logic [15:0] trap;
        logic [15:0] dest;
        int          lat;
        logic [15:0] rdata;
        logic [15:0] e_addr;
        logic        e_wr;
        logic [1:0]  e_be;
        logic [15:0] e_wdata;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {15'd0, act}, {15'd0, exp});
    endtask

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; is_ldi = 0; is_sti = 0; is_ldb_stb = 0;
        addr_sel = 2'd0; alu_out = 0; addr_adder_out = 0; trapvector = 0;
        dest_data = 0; ext_stall = 0; d_resp = 0; d_rdata = 16'hDEAD;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        mem_read = v.mr; mem_write = v.mw; is_ldb_stb = v.byt; addr_sel = v.sel;
        alu_out = v.alu; addr_adder_out = v.adder; trapvector = v.trap; dest_data = v.dest;
        for (int c = 0; c <= v.lat; c++) begin
            if (c > 0) next_cycle();
            d_resp  = (c == v.lat);
            d_rdata = (c == v.lat) ? v.rdata : 16'hDEAD;
            #3;
            chk1({tag, " d_read"}, d_read, ~v.e_wr);
            chk1({tag, " d_write"}, d_write, v.e_wr);
            chk({tag, " d_address"}, d_address, v.e_addr);
            chk({tag, " d_byte_enable"}, {14'd0, d_byte_enable}, {14'd0, v.e_be});
            if (v.e_wr) chk({tag, " d_wdata"}, d_wdata, v.e_wdata);
            chk1({tag, " stall"}, mem_stall, 1'b1);
        end
        next_cycle();
        d_resp = 0;
        #3;
        chk({tag, " done mem_rdata"}, mem_rdata, v.e_rdata);
        chk1({tag, " done stall"}, mem_stall, 1'b0);
        chk1({tag, " done strobe"}, d_read | d_write, 1'b0);
        next_cycle();
        clear_inputs();
        #3;
        chk({tag, " idle mem_rdata"}, mem_rdata, 16'h0000);
        chk1({tag, " idle stall"}, mem_stall, 1'b0);
    endtask

    initial begin
        //          mr mw byt sel alu       adder     trap      dest      lat rdata     e_addr    wr be     e_wdata   e_rdata
        vecs[0] = '{1, 0, 0, 2'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 2, 16'hBEEF, 16'h1234, 0, 2'b11, 16'h0000, 16'hBEEF};
        vecs[1] = '{0, 1, 1, 2'd1, 16'h0000, 16'h2001, 16'h0000, 16'h00A5, 1, 16'h0000, 16'h2001, 1, 2'b10, 16'hA5A5, 16'h0000};
        vecs[2] = '{1, 0, 1, 2'd0, 16'h3010, 16'h0000, 16'h0000, 16'h0000, 0, 16'h12AB, 16'h3010, 0, 2'b01, 16'h0000, 16'h00AB};
        vecs[3] = '{1, 0, 1, 2'd0, 16'h3011, 16'h0000, 16'h0000, 16'h0000, 0, 16'h12AB, 16'h3011, 0, 2'b10, 16'h0000, 16'h0012};
        vecs[4] = '{1, 0, 0, 2'd3, 16'h4567, 16'h0000, 16'h0000, 16'h0000, 1, 16'hCAFE, 16'h4566, 0, 2'b11, 16'h0000, 16'hCAFE};
        vecs[5] = '{1, 0, 0, 2'd2, 16'h1111, 16'h2222, 16'h0040, 16'h0000, 0, 16'h1000, 16'h0040, 0, 2'b11, 16'h0000, 16'h1000};
        vecs[6] = '{0, 1, 0, 2'd1, 16'h0000, 16'h2003, 16'h0000, 16'h9876, 1, 16'h0000, 16'h2002, 1, 2'b11, 16'h9876, 16'h0000};
        vecs[7] = '{1, 1, 0, 2'd0, 16'h0100, 16'h0000, 16'h0000, 16'h7777, 0, 16'h5555, 16'h0100, 0, 2'b11, 16'h0000, 16'h5555};
        vecs[8] = '{0, 1, 1, 2'd1, 16'h0000, 16'h2000, 16'h0000, 16'h12C3, 0, 16'h0000, 16'h2000, 1, 2'b01, 16'hC3C3, 16'h0000};

        clear_inputs();
        reset = 1;
        mem_read = 1; alu_out = 16'h1234;
        #3;
        chk1("reset d_read", d_read, 1'b0);
        chk1("reset stall", mem_stall, 1'b0);
        chk("reset mem_rdata", mem_rdata, 16'h0000);
        next_cycle();
        clear_inputs();
        reset = 0;
        #3;
        chk1("post-reset stall", mem_stall, 1'b0);

        for (int i = 0; i < 9; i++) begin
            next_cycle();
            run_vec(vecs[i], i);
        end

        // LDI: pointer read at 3000 -> 4000, data read at 4000 -> 0042
        next_cycle();
        mem_read = 1; is_ldi = 1; addr_sel = 2'd1; addr_adder_out = 16'h3000;
        #3;
        chk1("ldi p0 d_read", d_read, 1'b1);
        chk("ldi p0 addr", d_address, 16'h3000);
        next_cycle();
        d_resp = 1; d_rdata = 16'h4000;
        #3;
        chk("ldi p1 addr held", d_address, 16'h3000);
        chk1("ldi p1 stall", mem_stall, 1'b1);
        next_cycle();
        d_resp = 1; d_rdata = 16'h0042;
        #3;
        chk1("ldi ind d_read", d_read, 1'b1);
        chk1("ldi ind d_write", d_write, 1'b0);
        chk("ldi ind addr", d_address, 16'h4000);
        chk1("ldi ind stall", mem_stall, 1'b1);
        next_cycle();
        d_resp = 0;
        #3;
        chk("ldi done mem_rdata", mem_rdata, 16'h0042);
        chk1("ldi done stall", mem_stall, 1'b0);
        next_cycle();
        clear_inputs();

        // STI: pointer read returns 5000, then write of dest_data there
        next_cycle();
        mem_write = 1; is_sti = 1; addr_sel = 2'd0; alu_out = 16'h3100; dest_data = 16'h7777;
        d_resp = 1; d_rdata = 16'h5000;
        #3;
        chk1("sti p d_read", d_read, 1'b1);
        chk1("sti p d_write", d_write, 1'b0);
        chk("sti p addr", d_address, 16'h3100);
        next_cycle();
        d_resp = 0;
        #3;
        chk1("sti ind d_write", d_write, 1'b1);
        chk1("sti ind d_read", d_read, 1'b0);
        chk("sti ind addr", d_address, 16'h5000);
        chk("sti ind wdata", d_wdata, 16'h7777);
        chk({14'd0, d_byte_enable}, 16'h0003, 16'h0003) ;
        next_cycle();
        d_resp = 1; d_rdata = 16'h0000;
        #3;
        chk("sti ind addr held", d_address, 16'h5000);
        next_cycle();
        d_resp = 0;
        #3;
        chk1("sti done stall", mem_stall, 1'b0);
        chk1("sti done strobe", d_write | d_read, 1'b0);
        next_cycle();
        clear_inputs();

        // ext_stall holds DONE for 3 cycles; a stray d_resp there is ignored
        next_cycle();
        mem_read = 1; alu_out = 16'h0200; d_resp = 1; d_rdata = 16'h1111; ext_stall = 1;
        #3;
        chk("hold addr", d_address, 16'h0200);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            d_resp = (k == 1); d_rdata = 16'h2222;
            #3;
            chk("hold mem_rdata", mem_rdata, 16'h1111);
            chk1("hold no strobe", d_read | d_write, 1'b0);
            chk1("hold stall", mem_stall, 1'b1);
        end
        next_cycle();
        d_resp = 0; ext_stall = 0;
        #3;
        chk("release mem_rdata", mem_rdata, 16'h1111);
        chk1("release stall", mem_stall, 1'b0);
        next_cycle();
        clear_inputs();
        #3;
        chk("release idle mem_rdata", mem_rdata, 16'h0000);

        // Reset asserted mid-IND; the held request restarts with a fresh first access
        next_cycle();
        mem_read = 1; is_ldi = 1; addr_sel = 2'd1; addr_adder_out = 16'h3000;
        d_resp = 1; d_rdata = 16'h4000;
        #3;
        chk("rst p addr", d_address, 16'h3000);
        next_cycle();
        d_resp = 0;
        #3;
        chk("rst ind addr", d_address, 16'h4000);
        reset = 1;
        #1;
        chk1("rst mid d_read", d_read, 1'b0);
        chk1("rst mid d_write", d_write, 1'b0);
        chk1("rst mid stall", mem_stall, 1'b0);
        next_cycle();
        reset = 0;
        #3;
        chk1("rst fresh d_read", d_read, 1'b1);
        chk("rst fresh addr", d_address, 16'h3000);
        chk1("rst fresh stall", mem_stall, 1'b1);
        next_cycle();
        clear_inputs();
        #3;
        chk1("rst idle stall", mem_stall, 1'b0);

        // d_resp in IDLE without a request must not advance the FSM
        next_cycle();
        d_resp = 1; d_rdata = 16'hFFFF;
        #3;
        chk1("stray stall", mem_stall, 1'b0);
        next_cycle();
        d_resp = 0; mem_read = 1; alu_out = 16'h0300;
        #3;
        chk1("stray then d_read", d_read, 1'b1);
        chk("stray then addr", d_address, 16'h0300);
        chk("stray then mem_rdata", mem_rdata, 16'h0000);
        next_cycle();
        d_resp = 1; d_rdata = 16'h0123;
        #3;
        next_cycle();
        d_resp = 0;
        #3;
        chk("stray done mem_rdata", mem_rdata, 16'h0123);
        next_cycle();
        clear_inputs();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
